muldiv_unit: RTL

Parametrised iterative multiply/divide execution unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits in the EX stage beside the single-cycle ALU path and receives operands after forwarding. It holds the pipeline through a valid/ready handshake while it iterates, and returns the result with its destination register tag to the EX/MEM register.

---
 rtl/muldiv_unit_pkg.sv | 45 ++++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// M-extension instruction ids, internal op encoding and the id decoder.
package muldiv_unit_pkg;

   localparam logic [5:0] INSTR_MUL    = 6'd40;
   localparam logic [5:0] INSTR_MULH   = 6'd41;
   localparam logic [5:0] INSTR_MULHSU = 6'd42;
   localparam logic [5:0] INSTR_MULHU  = 6'd43;
   localparam logic [5:0] INSTR_DIV    = 6'd44;
   localparam logic [5:0] INSTR_DIVU   = 6'd45;
   localparam logic [5:0] INSTR_REM    = 6'd46;
   localparam logic [5:0] INSTR_REMU   = 6'd47;

   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } md_op_e;

   typedef struct packed {
      logic   valid;
      md_op_e op;
   } md_dec_t;

   function automatic md_dec_t decode_m(input logic [5:0] id);
      md_dec_t d;
      d.valid = 1'b1;
      d.op    = OP_MUL;
      case (id)
         INSTR_MUL:    d.op = OP_MUL;
         INSTR_MULH:   d.op = OP_MULH;
         INSTR_MULHSU: d.op = OP_MULHSU;
         INSTR_MULHU:  d.op = OP_MULHU;
         INSTR_DIV:    d.op = OP_DIV;
         INSTR_DIVU:   d.op = OP_DIVU;
         INSTR_REM:    d.op = OP_REM;
         INSTR_REMU:   d.op = OP_REMU;
         default:      d.valid = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic op_is_div(input md_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational UNROLL-step iterator: shift-add multiply or restoring
// shift-subtract divide on a 2*XLEN unsigned accumulator {hi, lo}.
module muldiv_step #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic                is_div,
   input  logic [2*XLEN-1:0]   acc_in,
   input  logic [XLEN-1:0]     operand,
   output logic [2*XLEN-1:0]   acc_out
);

   logic [2*XLEN-1:0] acc;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     sh;

   always_comb begin
      acc = acc_in;
      sum = '0;
      sh  = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (!is_div) begin
            // Multiplier bits drain out of lo LSB-first while the product grows in from hi.
            sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
            acc = {sum, acc[XLEN-1:1]};
         end else begin
            sh = acc[2*XLEN-1:XLEN-1];
            if (sh >= {1'b0, operand})
               acc = {sh[XLEN-1:0] - operand, acc[XLEN-2:0], 1'b1};
            else
               acc = {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end
      acc_out = acc;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension execution unit: FSM, iteration counter, operand sign
// handling, special-case shortcuts and valid/ready handshake around muldiv_step.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      instr_id,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   input  logic [4:0]      in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            busy
);

   localparam int N     = XLEN / UNROLL;
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   if ((XLEN % UNROLL) != 0 || (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8))
   begin : g_bad_cfg
      $error("muldiv_unit: UNROLL must be 1/2/4/8 and divide XLEN");
   end

   typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_e;

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   iter_cnt, cnt_nxt;
   md_op_e             op_q;
   logic               neg_q;
   logic [2*XLEN-1:0]  acc_q, acc_step;
   logic [XLEN-1:0]    opb_q;

   md_dec_t            dec;
   logic               accept, a_signed, b_signed, neg_a, neg_b, neg_res;
   logic               special, load_result;
   logic [XLEN-1:0]    mag_a, mag_b, special_val, fix_result, result_nxt;
   logic [2*XLEN-1:0]  prod;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

   // Accept-time decode: magnitudes, result sign and shortcut results.
   always_comb begin
      dec      = decode_m(instr_id);
      accept   = in_valid && in_ready && !flush && dec.valid;
      a_signed = (dec.op == OP_MUL) || (dec.op == OP_MULH) || (dec.op == OP_MULHSU) ||
                 (dec.op == OP_DIV) || (dec.op == OP_REM);
      b_signed = (dec.op == OP_MUL) || (dec.op == OP_MULH) ||
                 (dec.op == OP_DIV) || (dec.op == OP_REM);
      neg_a    = a_signed && rs1_value[XLEN-1];
      neg_b    = b_signed && rs2_value[XLEN-1];
      mag_a    = neg_a ? -rs1_value : rs1_value;
      mag_b    = neg_b ? -rs2_value : rs2_value;
      case (dec.op)
         OP_REM, OP_MULHSU:          neg_res = neg_a;
         OP_MULHU, OP_DIVU, OP_REMU: neg_res = 1'b0;
         default:                    neg_res = neg_a ^ neg_b;
      endcase
      special     = 1'b0;
      special_val = '0;
      case (dec.op)
         OP_DIV, OP_DIVU: begin
            if (rs2_value == '0) begin
               special     = 1'b1;
               special_val = '1;
            end else if (dec.op == OP_DIV && rs1_value == MOST_NEG && rs2_value == '1) begin
               special     = 1'b1;
               special_val = MOST_NEG;
            end
         end
         OP_REM, OP_REMU: begin
            if (rs2_value == '0) begin
               special     = 1'b1;
               special_val = rs1_value;
            end else if (dec.op == OP_REM && rs1_value == MOST_NEG && rs2_value == '1) begin
               special     = 1'b1;
               special_val = '0;
            end
         end
         default: ;
      endcase
   end

   muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
      .is_div  (op_is_div(op_q)),
      .acc_in  (acc_q),
      .operand (opb_q),
      .acc_out (acc_step)
   );

   // Sign fixup and result selection once iteration finishes.
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      case (op_q)
         OP_MUL:                       fix_result = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_result = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
         default:                      fix_result = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      endcase
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = iter_cnt;
      load_result = 1'b0;
      result_nxt  = fix_result;
      case (state)
         IDLE: if (accept) begin
            cnt_nxt = '0;
            if (special) begin
               state_nxt   = DONE;
               load_result = 1'b1;
               result_nxt  = special_val;
            end else begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            cnt_nxt = iter_cnt + 1'b1;
            if (iter_cnt == CNT_W'(N - 1)) state_nxt = FIXUP;
         end
         FIXUP: begin
            load_result = 1'b1;
            state_nxt   = DONE;
         end
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt   = IDLE;
         load_result = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         iter_cnt   <= '0;
         out_result <= '0;
         out_rd     <= '0;
      end else begin
         state    <= state_nxt;
         iter_cnt <= cnt_nxt;
         if (load_result) out_result <= result_nxt;
         if (accept)      out_rd     <= in_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q  <= dec.op;
         neg_q <= neg_res;
         acc_q <= {{XLEN{1'b0}}, mag_a};
         opb_q <= mag_b;
      end else if (state == BUSY) begin
         acc_q <= acc_step;
      end
   end

endmodule
